// File: rtl/layer1_maxpool.sv
// layer1_maxpool: 2x2/stride-2 max pool over a raster conv stream with a half-width row buffer.
// Optional MAXPOOL_RELU_EN clamps negative pooled channels to zero.
module layer1_maxpool #(
    parameter int CH   = 8,
    parameter int DW   = 16,
    parameter int IN_W = 30,
    parameter int IN_H = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] out_data,
    output logic             frame_done
);
    localparam int CW   = $clog2(IN_W);
    localparam int RW   = $clog2(IN_H);
    localparam int NOUT = (IN_W / 2) * (IN_H / 2);
    localparam int OW   = $clog2(NOUT);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

    typedef logic [CH*DW-1:0] pix_t;

    function automatic pix_t vmax(input pix_t a, input pix_t b);
        pix_t m;
        m = '0;
        for (int k = 0; k < CH; k++)
            m[k*DW +: DW] = $signed(a[k*DW +: DW]) > $signed(b[k*DW +: DW]) ? a[k*DW +: DW] : b[k*DW +: DW];
        return m;
    endfunction

    function automatic pix_t act(input pix_t a);
        pix_t m;
        m = a;
`ifdef MAXPOOL_RELU_EN
        for (int k = 0; k < CH; k++)
            m[k*DW +: DW] = a[k*DW + DW - 1] ? '0 : a[k*DW +: DW];
`endif
        return m;
    endfunction

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [OW-1:0] out_cnt;
    pix_t          hold;
    pix_t          pair;
    pix_t          rowbuf [IN_W/2];
    logic [CW-2:0] idx;
    logic          accept;
    logic          out_fire;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign idx      = col[CW-1:1];
    assign pair     = vmax(hold, in_data);

    // Row buffer holds the horizontal max of each even-row pair; no reset needed.
    always_ff @(posedge clk)
        if (accept && col[0] && !row[0])
            rowbuf[idx] <= pair;

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_cnt    <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_fire && out_cnt == OUT_LAST;
            if (out_fire) begin
                out_valid <= 1'b0;
                out_cnt   <= out_cnt == OUT_LAST ? '0 : out_cnt + 1'b1;
            end
            if (accept) begin
                col <= col == COL_LAST ? '0 : col + 1'b1;
                if (col == COL_LAST)
                    row <= row == ROW_LAST ? '0 : row + 1'b1;
                if (!col[0])
                    hold <= in_data;
                if (col[0] && row[0]) begin
                    out_data  <= act(vmax(rowbuf[idx], pair));
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_layer1_maxpool.sv
// tb_layer1_maxpool: randomized frames checked every cycle against a frame-image pooling model.
module tb_layer1_maxpool;
    localparam int W = 30, H = 30, NPIX = W * H, NOUT = (W / 2) * (H / 2);

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, frame_done;
    logic [127:0] in_data = '0, out_data;

    always #5 clk = ~clk;

    layer1_maxpool dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done)
    );

    int checks = 0, passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [127:0] img [NPIX];
    logic [127:0] outs [NOUT];
    logic [127:0] q [$];
    int pos = 0, popcnt = 0, fd_cnt = 0, tot_pops = 0;
    bit armed = 0, exp_fd = 0;

    function automatic logic [127:0] pool(input int p);
        logic [127:0] r;
        int offs [4];
        int m, v;
        offs = '{p - W - 1, p - W, p - 1, p};
        r = '0;
        for (int k = 0; k < 8; k++) begin
            m = -100000;
            for (int i = 0; i < 4; i++) begin
                v = int'($signed(img[offs[i]][k*16 +: 16]));
                if (v > m) m = v;
            end
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            r[k*16 +: 16] = 16'(m);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pos = 0;
            popcnt = 0;
            exp_fd = 0;
            armed = 1;
        end else if (armed) begin
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            if (q.size() != 0) chk("out_data", out_data, q[0]);
            chk("frame_done", 128'(frame_done), 128'(exp_fd));
            chk("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
            if (frame_done) fd_cnt++;
            exp_fd = 0;
            if (out_valid && out_ready && q.size() != 0) begin
                outs[popcnt] = q.pop_front();
                popcnt++;
                tot_pops++;
                if (popcnt == NOUT) begin
                    popcnt = 0;
                    exp_fd = 1;
                end
            end
            if (in_valid && in_ready) begin
                img[pos] = in_data;
                if ((pos / W) % 2 == 1 && (pos % W) % 2 == 1) q.push_back(pool(pos));
                pos = (pos + 1) % NPIX;
            end
        end
    end

    // Output-side pacing: 0 always ready, 1 random, 2 stall 10 cycles at first out_valid.
    int rdy_mode = 0, bp_hold = 0;
    bit bp_seen = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) out_ready = $urandom_range(3) != 0;
        else if (rdy_mode == 2) begin
            if (!bp_seen && out_valid) begin
                bp_seen = 1;
                bp_hold = 10;
            end
            out_ready = bp_hold == 0;
            if (bp_hold > 0) bp_hold--;
        end else out_ready = 1'b1;
    end

    function automatic logic [127:0] gen(input int mode, input int p);
        logic [127:0] d;
        for (int k = 0; k < 8; k++)
            d[k*16 +: 16] = mode == 1 ? 16'(p) : 16'($urandom_range(65535));
        if (mode == 2) begin
            if (p == 0) d[15:0] = 16'hFFFB;
            else if (p == 1) d[15:0] = 16'hFFFD;
            else if (p == W) d[15:0] = 16'hFFF9;
            else if (p == W + 1) d[15:0] = 16'hFFFF;
            else if (p == 2) d[15:0] = 16'h8000;
            else if (p == 3) d[15:0] = 16'h7FFF;
            else if (p == W + 2) d[15:0] = 16'h0000;
            else if (p == W + 3) d[15:0] = 16'h0001;
            else if (p == 4 || p == 5 || p == W + 4 || p == W + 5)
                for (int k = 0; k < 8; k++)
                    d[k*16 +: 16] = p == 4 ? 16'(k) : p == 5 ? 16'(7 - k) : p == W + 4 ? 16'd3 : 16'd4;
        end
        return d;
    endfunction

    task automatic drive_frame(input int mode, input int vp, input int abort_at);
        int p = 0, guard = 0;
        bit acc;
        while (p < NPIX && guard < 20000) begin
            in_valid = $urandom_range(99) < vp;
            in_data = gen(mode, p);
            if (p == abort_at) begin
                in_valid = 1'b1;
                rst = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                chk("post_reset_out_valid", 128'(out_valid), 128'(0));
                @(posedge clk);
                #1;
                return;
            end
            if (acc) p++;
            guard++;
        end
        in_valid = 1'b0;
        chk("drive_timeout", 128'(p), 128'(NPIX));
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 128'(q.size()), 128'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    int t0, f0;
    logic [15:0] pc_exp [8];

    initial begin
        pc_exp = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd4, 16'd5, 16'd6, 16'd7};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_data", out_data, 128'(0));
        chk("reset_frame_done", 128'(frame_done), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        rdy_mode = 0;
        t0 = tot_pops; f0 = fd_cnt;
        drive_frame(1, 100, -1);
        drain();
        chk("ramp_count", 128'(tot_pops - t0), 128'(NOUT));
        chk("ramp_frame_done", 128'(fd_cnt - f0), 128'(1));
        chk("ramp_first", 128'(outs[0][15:0]), 128'(31));
        chk("ramp_last", 128'(outs[NOUT-1][15:0]), 128'(899));
        chk("ramp_r1c2", outs[17], {8{16'd95}});

        bp_seen = 0;
        rdy_mode = 2;
        t0 = tot_pops; f0 = fd_cnt;
        drive_frame(2, 100, -1);
        drain();
        chk("bp_count", 128'(tot_pops - t0), 128'(NOUT));
        chk("bp_frame_done", 128'(fd_cnt - f0), 128'(1));
`ifdef MAXPOOL_RELU_EN
        chk("signed_neg", 128'(outs[0][15:0]), 128'(16'h0000));
`else
        chk("signed_neg", 128'(outs[0][15:0]), 128'(16'hFFFF));
`endif
        chk("signed_extremes", 128'(outs[1][15:0]), 128'(16'h7FFF));
        for (int k = 0; k < 8; k++) chk($sformatf("per_channel_%0d", k), 128'(outs[2][k*16 +: 16]), 128'(pc_exp[k]));

        rdy_mode = 1;
        t0 = tot_pops; f0 = fd_cnt;
        drive_frame(0, 50, -1);
        drive_frame(0, 50, -1);
        drain();
        chk("gaps_count", 128'(tot_pops - t0), 128'(2 * NOUT));
        chk("gaps_frame_done", 128'(fd_cnt - f0), 128'(2));

        drive_frame(0, 100, 17 * W + 9);
        t0 = tot_pops; f0 = fd_cnt;
        drive_frame(0, 100, -1);
        drain();
        chk("restart_count", 128'(tot_pops - t0), 128'(NOUT));
        chk("restart_frame_done", 128'(fd_cnt - f0), 128'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
